fir_tap_sequencer: RTL and testbench

//  Controller for the FIR MAC datapath. Accepts one input sample by valid/ready handshake and writes it into a

---
 rtl/fir_pkg.sv | 21 ++
 rtl/fir_mod_cnt.sv | 37 +++
 rtl/fir_tap_sequencer.sv | 147 ++++++++++++++
 tb/tb_fir_tap_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR tap sequencer: FSM states, overrun
// counter width, and the coefficient/sample RAM read latency.
package fir_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MAC   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } fir_state_t;

  localparam int OVR_CNT_W  = 8;
  localparam int RAM_RD_LAT = 1;

  // Saturating increment for the overrun counter.
  function automatic logic [OVR_CNT_W-1:0] sat_inc(input logic [OVR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fir_mod_cnt.sv
// Modulo-N up counter with synchronous clear and enable; clear has priority.
module fir_mod_cnt #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_reg;
  logic [W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr_i) begin
      cnt_next = '0;
    end else if (en_i) begin
      cnt_next = (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt_o = cnt_reg;

endmodule

// File: rtl/fir_tap_sequencer.sv
// Sequencer for the FIR MAC datapath: accepts a sample, writes it into the circular
// sample RAM, walks all taps, then loads the result. FIR_OVERRUN_EN adds overrun tracking.
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter  int N_TAPS = 16,
  localparam int ADDR_W = $clog2(N_TAPS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              smp_valid_i,
  output logic              smp_ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [ADDR_W-1:0] rd_smp_addr_o,
  output logic [ADDR_W-1:0] rd_coef_addr_o,
  output logic              mac_clr_o,
  output logic              mac_en_o,
  output logic              res_ld_o,
  output logic              busy_o
`ifdef FIR_OVERRUN_EN
  ,
  input  logic                 ovr_clr_i,
  output logic                 ovr_o,
  output logic [OVR_CNT_W-1:0] ovr_cnt_o
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_TAPS - 1);

  fir_state_t state_reg;
  fir_state_t state_next;

  logic [ADDR_W-1:0] head_cnt;
  logic [ADDR_W-1:0] tap_cnt;

  logic              wr_en_reg,  wr_en_next;
  logic              mac_clr_reg, mac_clr_next;
  logic              res_ld_reg, res_ld_next;
  logic [ADDR_W-1:0] rd_smp_reg, rd_smp_next;

  logic                rd_issued;
  logic [RAM_RD_LAT:0] rd_pipe_next;
  logic [RAM_RD_LAT-1:0] rd_pipe_reg;

  // head advances once per frame after the write; tap runs 0..N_TAPS-1 in MAC
  fir_mod_cnt #(.N(N_TAPS), .W(ADDR_W)) u_head_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (1'b0),
    .en_i  (state_reg == ST_LOAD),
    .cnt_o (head_cnt)
  );

  fir_mod_cnt #(.N(N_TAPS), .W(ADDR_W)) u_tap_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (state_reg == ST_LOAD),
    .en_i  (state_reg == ST_MAC),
    .cnt_o (tap_cnt)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (smp_valid_i) state_next = ST_LOAD;
      ST_LOAD:  state_next = ST_MAC;
      ST_MAC:   if (tap_cnt == LAST_ADDR) state_next = ST_DRAIN;
      ST_DRAIN: state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Strobes are registered, so they are decoded from the state being entered.
  always_comb begin
    wr_en_next   = (state_next == ST_LOAD);
    mac_clr_next = (state_next == ST_LOAD);
    res_ld_next  = (state_next == ST_DONE);
    rd_smp_next  = rd_smp_reg;
    case (state_reg)
      ST_LOAD: rd_smp_next = head_cnt;
      ST_MAC:  rd_smp_next = (rd_smp_reg == '0) ? LAST_ADDR : rd_smp_reg - 1'b1;
      default: rd_smp_next = rd_smp_reg;
    endcase
  end

  // mac_en follows the read issue by the RAM read latency.
  assign rd_issued    = (state_reg == ST_MAC);
  assign rd_pipe_next = {rd_pipe_reg, rd_issued};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_en_reg   <= 1'b0;
      mac_clr_reg <= 1'b0;
      res_ld_reg  <= 1'b0;
      rd_smp_reg  <= '0;
      rd_pipe_reg <= '0;
    end else begin
      wr_en_reg   <= wr_en_next;
      mac_clr_reg <= mac_clr_next;
      res_ld_reg  <= res_ld_next;
      rd_smp_reg  <= rd_smp_next;
      rd_pipe_reg <= rd_pipe_next[RAM_RD_LAT-1:0];
    end
  end

  assign smp_ready_o    = (state_reg == ST_IDLE);
  assign busy_o         = (state_reg != ST_IDLE);
  assign wr_en_o        = wr_en_reg;
  assign wr_addr_o      = head_cnt;
  assign rd_smp_addr_o  = rd_smp_reg;
  assign rd_coef_addr_o = tap_cnt;
  assign mac_clr_o      = mac_clr_reg;
  assign mac_en_o       = rd_pipe_reg[RAM_RD_LAT-1];
  assign res_ld_o       = res_ld_reg;

`ifdef FIR_OVERRUN_EN
  logic                 ovr_reg;
  logic [OVR_CNT_W-1:0] ovr_cnt_reg;
  logic                 ovr_event;

  assign ovr_event = smp_valid_i && !smp_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i || ovr_clr_i) begin
      ovr_reg     <= 1'b0;
      ovr_cnt_reg <= '0;
    end else if (ovr_event) begin
      ovr_reg     <= 1'b1;
      ovr_cnt_reg <= sat_inc(ovr_cnt_reg);
    end
  end

  assign ovr_o     = ovr_reg;
  assign ovr_cnt_o = ovr_cnt_reg;
`endif

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Randomized bench for fir_tap_sequencer: a 4-tap and a 5-tap instance share stimulus and
// are compared every cycle against a frame-offset model. Define FIR_OVERRUN_EN to cover overrun.
module tb_fir_tap_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic smp_valid;
  logic ovr_clr;

  logic       ready_a, wr_en_a, clr_a, en_a, ld_a, busy_a;
  logic [1:0] wr_addr_a, rd_smp_a, rd_coef_a;
  logic       ready_b, wr_en_b, clr_b, en_b, ld_b, busy_b;
  logic [2:0] wr_addr_b, rd_smp_b, rd_coef_b;
`ifdef FIR_OVERRUN_EN
  logic       ovr_a, ovr_b;
  logic [7:0] ovr_cnt_a, ovr_cnt_b;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int n_of     [2] = '{4, 5};
  int m_busy   [2];
  int m_d      [2];
  int m_newest [2];
  int m_head   [2];
  int m_ovr    [2];
  int m_ovr_cnt[2];

  always #5 clk = ~clk;

  fir_tap_sequencer #(.N_TAPS(4)) u_dut_a (
    .clk_i          (clk),
    .rst_i          (rst),
    .smp_valid_i    (smp_valid),
    .smp_ready_o    (ready_a),
    .wr_en_o        (wr_en_a),
    .wr_addr_o      (wr_addr_a),
    .rd_smp_addr_o  (rd_smp_a),
    .rd_coef_addr_o (rd_coef_a),
    .mac_clr_o      (clr_a),
    .mac_en_o       (en_a),
    .res_ld_o       (ld_a),
    .busy_o         (busy_a)
`ifdef FIR_OVERRUN_EN
    ,
    .ovr_clr_i      (ovr_clr),
    .ovr_o          (ovr_a),
    .ovr_cnt_o      (ovr_cnt_a)
`endif
  );

  fir_tap_sequencer #(.N_TAPS(5)) u_dut_b (
    .clk_i          (clk),
    .rst_i          (rst),
    .smp_valid_i    (smp_valid),
    .smp_ready_o    (ready_b),
    .wr_en_o        (wr_en_b),
    .wr_addr_o      (wr_addr_b),
    .rd_smp_addr_o  (rd_smp_b),
    .rd_coef_addr_o (rd_coef_b),
    .mac_clr_o      (clr_b),
    .mac_en_o       (en_b),
    .res_ld_o       (ld_b),
    .busy_o         (busy_b)
`ifdef FIR_OVERRUN_EN
    ,
    .ovr_clr_i      (ovr_clr),
    .ovr_o          (ovr_b),
    .ovr_cnt_o      (ovr_cnt_b)
`endif
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_d[i] = 0; m_head[i] = 0; m_newest[i] = 0;
      m_ovr[i] = 0;  m_ovr_cnt[i] = 0;
    end
  endtask

  // Frame offset d counts cycles since the accept: 1 = write, 2..N+1 = reads,
  // 3..N+2 = accumulate, N+3 = result load, then idle.
  task automatic check_cycle(input int it);
    for (int i = 0; i < 2; i++) begin
      int    n, d, o_rdy, o_busy, o_we, o_wa, o_rs, o_rc, o_clr, o_en, o_ld;
      bit    bz, win;
      string p;
      n  = n_of[i];
      d  = m_d[i];
      bz = (m_busy[i] != 0);
      p  = (i == 0) ? "a." : "b.";
      if (i == 0) begin
        o_rdy = int'(ready_a); o_busy = int'(busy_a); o_we = int'(wr_en_a);
        o_wa = int'(wr_addr_a); o_rs = int'(rd_smp_a); o_rc = int'(rd_coef_a);
        o_clr = int'(clr_a); o_en = int'(en_a); o_ld = int'(ld_a);
      end else begin
        o_rdy = int'(ready_b); o_busy = int'(busy_b); o_we = int'(wr_en_b);
        o_wa = int'(wr_addr_b); o_rs = int'(rd_smp_b); o_rc = int'(rd_coef_b);
        o_clr = int'(clr_b); o_en = int'(en_b); o_ld = int'(ld_b);
      end
      win = bz && d >= 2 && d <= n + 1;
      check_eq({p, "ready"},   o_rdy,  int'(!bz));
      check_eq({p, "busy"},    o_busy, int'(bz));
      check_eq({p, "wr_en"},   o_we,   int'(bz && d == 1));
      check_eq({p, "mac_clr"}, o_clr,  int'(bz && d == 1));
      check_eq({p, "wr_addr"}, o_wa,   m_head[i]);
      check_eq({p, "mac_en"},  o_en,   int'(bz && d >= 3 && d <= n + 2));
      check_eq({p, "res_ld"},  o_ld,   int'(bz && d == n + 3));
      check_eq({p, "rd_coef"}, o_rc,   win ? d - 2 : 0);
      if (win) check_eq({p, "rd_smp"}, o_rs, (m_newest[i] - (d - 2) + n) % n);
      if (it == 0) check_eq({p, "rst_rd_smp"}, o_rs, 0);
    end
`ifdef FIR_OVERRUN_EN
    check_eq("a.ovr",     int'(ovr_a),     m_ovr[0]);
    check_eq("a.ovr_cnt", int'(ovr_cnt_a), m_ovr_cnt[0]);
    check_eq("b.ovr",     int'(ovr_b),     m_ovr[1]);
    check_eq("b.ovr_cnt", int'(ovr_cnt_b), m_ovr_cnt[1]);
`endif
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      int n;
      n = n_of[i];
      if (ovr_clr) begin
        m_ovr[i] = 0; m_ovr_cnt[i] = 0;
      end else if (smp_valid && m_busy[i] != 0) begin
        m_ovr[i] = 1;
        if (m_ovr_cnt[i] < 255) m_ovr_cnt[i]++;
      end
      if (m_busy[i] == 0) begin
        if (smp_valid) begin
          m_busy[i] = 1; m_d[i] = 1; m_newest[i] = m_head[i];
          $display("accept inst=%0d taps=%0d slot=%0d cycle=%0d", i, n, m_head[i], cyc);
        end
      end else begin
        if (m_d[i] == 1) m_head[i] = (m_head[i] + 1) % n;
        if (m_d[i] == n + 3) begin
          m_busy[i] = 0; m_d[i] = 0;
        end else begin
          m_d[i]++;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; smp_valid = 1'b0; ovr_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int it = 0; it < 1000; it++) begin
      check_cycle(it);
      // drive this cycle's inputs, then advance the model across the next edge
      rst = 1'b0; ovr_clr = 1'b0;
      if (it < 200) begin
        smp_valid = ($urandom_range(0, 3) == 0);
      end else if (it < 660) begin
        smp_valid = 1'b1;
        ovr_clr   = (it == 630 || it == 645);
      end else begin
        smp_valid = ($urandom_range(0, 1) == 1);
        ovr_clr   = ($urandom_range(0, 19) == 0);
        rst       = (m_busy[0] != 0 && m_d[0] == 4 && $urandom_range(0, 2) == 0)
                    || ($urandom_range(0, 99) == 0);
      end
`ifdef FIR_OVERRUN_EN
      if (it == 620) begin
        check_eq("a.ovr_sat", int'(ovr_cnt_a), 255);
        check_eq("b.ovr_sat", int'(ovr_cnt_b), 255);
      end
`endif
      model_step();
      cyc++;
      @(negedge clk);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
